// File: rtl/io_map_pkg.sv
// Shared definitions for the IO page: register offsets, STATUS bit positions,
// UART state encodings and the baud divisor helper.
package io_map_pkg;

    localparam logic [2:0] IO_LEDS     = 3'd0;
    localparam logic [2:0] IO_UART_DAT = 3'd1;
    localparam logic [2:0] IO_STATUS   = 3'd2;
    localparam logic [2:0] IO_RX_DATA  = 3'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_MSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per UART bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with occupancy count; rd_data is the entry at the read pointer.
// Handshake: push is honoured only while !full, pop only while !empty; rd_data is the head whenever !empty.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("io_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_periph.sv
// IO page: LED register, FIFO-buffered UART transmitter and a pollable status word.
// Define IO_UART_RX_EN to add the RXD receiver and the RX_DATA register.
module io_uart_periph
    import io_map_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IO_mem_addr,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [31:0] IO_mem_rdata,
    output logic [4:0]  LEDS,
    output logic        TXD
`ifdef IO_UART_RX_EN
    ,
    input  logic        RXD
`endif
);
    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int BW  = $clog2(DIV + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("io_uart_periph: baud divisor must be at least 2");
    end

    logic [2:0]  reg_sel;
    logic        wr_leds, wr_dat, wr_status;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic        ovf;
    logic        rx_valid, rx_ovr;
    logic [7:0]  rx_byte;
    logic [31:0] status;
    logic        unused_bits;

    assign reg_sel     = IO_mem_addr[4:2];
    assign wr_leds     = IO_mem_wr && (reg_sel == IO_LEDS);
    assign wr_dat      = IO_mem_wr && (reg_sel == IO_UART_DAT);
    assign wr_status   = IO_mem_wr && (reg_sel == IO_STATUS);
    assign fifo_push   = wr_dat && !fifo_full;
    assign unused_bits = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata[31:8], IO_mem_wdata[3]};

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (fifo_push),
        .wr_data (IO_mem_wdata[7:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A write to a full FIFO is dropped and flagged, regardless of a same-edge pop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            LEDS <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr_leds) LEDS <= IO_mem_wdata[4:0];
            if (wr_dat && fifo_full) ovf <= 1'b1;
            else if (wr_status && IO_mem_wdata[2]) ovf <= 1'b0;
        end
    end

    tx_state_t     tx_state, tx_state_nx;
    logic [BW-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]    tx_bit, tx_bit_nx;
    logic [7:0]    tx_sh, tx_sh_nx;
    logic          txd_nx;

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_sh_nx    = tx_sh;
        txd_nx      = TXD;
        fifo_pop    = 1'b0;
        if (tx_state != TX_IDLE && tx_cnt != '0) tx_cnt_nx = tx_cnt - 1'b1;
        case (tx_state)
            TX_IDLE: if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                tx_state_nx = TX_START;
                tx_cnt_nx   = DIV_M1;
                tx_sh_nx    = fifo_rdata;
                txd_nx      = 1'b0;
            end
            TX_START: if (tx_cnt == '0) begin
                tx_state_nx = TX_DATA;
                tx_cnt_nx   = DIV_M1;
                tx_bit_nx   = 3'd0;
                txd_nx      = tx_sh[0];
            end
            TX_DATA: if (tx_cnt == '0) begin
                tx_cnt_nx = DIV_M1;
                if (tx_bit == 3'd7) begin
                    tx_state_nx = TX_STOP;
                    txd_nx      = 1'b1;
                end else begin
                    tx_bit_nx = tx_bit + 1'b1;
                    tx_sh_nx  = {1'b0, tx_sh[7:1]};
                    txd_nx    = tx_sh[1];
                end
            end
            TX_STOP: if (tx_cnt == '0) begin
                // Chain straight into the next frame when a byte is waiting.
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    tx_state_nx = TX_START;
                    tx_cnt_nx   = DIV_M1;
                    tx_sh_nx    = fifo_rdata;
                    txd_nx      = 1'b0;
                end else begin
                    tx_state_nx = TX_IDLE;
                    txd_nx      = 1'b1;
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_sh    <= 8'd0;
            TXD      <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_sh    <= tx_sh_nx;
            TXD      <= txd_nx;
        end
    end

`ifdef IO_UART_RX_EN
    localparam logic [BW-1:0] HALF_M1 = BW'(DIV / 2 - 1);

    logic          wr_rx, rxd_s1, rxd_s2, rxd_prev, rx_done;
    rx_state_t     rx_state, rx_state_nx;
    logic [BW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]    rx_bit, rx_bit_nx;
    logic [7:0]    rx_sh, rx_sh_nx;

    assign wr_rx = IO_mem_wr && (reg_sel == IO_RX_DATA);

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_sh_nx    = rx_sh;
        rx_done     = 1'b0;
        if (rx_state != RX_IDLE && rx_cnt != '0) rx_cnt_nx = rx_cnt - 1'b1;
        case (rx_state)
            RX_IDLE: if (rxd_prev && !rxd_s2) begin
                rx_state_nx = RX_START;
                rx_cnt_nx   = HALF_M1;
            end
            RX_START: if (rx_cnt == '0) begin
                rx_state_nx = rxd_s2 ? RX_IDLE : RX_DATA;
                rx_cnt_nx   = DIV_M1;
                rx_bit_nx   = 3'd0;
            end
            RX_DATA: if (rx_cnt == '0) begin
                rx_sh_nx  = {rxd_s2, rx_sh[7:1]};
                rx_cnt_nx = DIV_M1;
                rx_bit_nx = rx_bit + 1'b1;
                if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
            end
            RX_STOP: if (rx_cnt == '0) begin
                rx_done     = rxd_s2;
                rx_state_nx = RX_IDLE;
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'd0;
            rx_byte  <= 8'd0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rxd_s1   <= RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_sh    <= rx_sh_nx;
            if (wr_status && IO_mem_wdata[3]) rx_ovr <= 1'b0;
            // A completed frame takes priority over a same-edge clear.
            if (rx_done) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
                if (rx_valid) rx_ovr <= 1'b1;
            end else if (wr_rx) begin
                rx_valid <= 1'b0;
            end
        end
    end
`else
    assign rx_valid = 1'b0;
    assign rx_ovr   = 1'b0;
    assign rx_byte  = 8'd0;
`endif

    always_comb begin
        status                            = '0;
        status[ST_BUSY]                   = (tx_state != TX_IDLE) || !fifo_empty;
        status[ST_FULL]                   = fifo_full;
        status[ST_OVF]                    = ovf;
        status[ST_RX_OVR]                 = rx_ovr;
        status[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count);
    end

    always_comb begin
        IO_mem_rdata = '0;
        case (reg_sel)
            IO_LEDS:    IO_mem_rdata = {27'd0, LEDS};
            IO_STATUS:  IO_mem_rdata = status;
            IO_RX_DATA: IO_mem_rdata = {23'd0, rx_valid, rx_byte};
            default:    IO_mem_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_io_uart_periph.sv
// Bench for io_uart_periph at DIV=10: bus driver tasks, a TXD frame monitor with an
// expected-byte queue, and a FIFO occupancy model built from accepted pushes and observed frame starts.
module tb_io_uart_periph;
    localparam int CLK_HZ = 10;
    localparam int BAUD   = 1;
    localparam int DEPTH  = 16;
    localparam int DIV    = 10;
    localparam int FRAME  = 10 * DIV;
    localparam logic [2:0] OFF_LEDS = 3'd0, OFF_DAT = 3'd1, OFF_STATUS = 3'd2, OFF_RX = 3'd3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr = 1'b0;
    logic [31:0] rdata;
    logic [4:0]  leds;
    logic        txd;
`ifdef IO_UART_RX_EN
    logic        rxd = 1'b1;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    logic [7:0] exp_q[$];
    int start_q[$];
    int accepted = 0;
    int started = 0;
    bit model_ovf = 1'b0;

    io_uart_periph #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .IO_mem_addr  (addr),
        .IO_mem_wdata (wdata),
        .IO_mem_wr    (wr),
        .IO_mem_rdata (rdata),
        .LEDS         (leds),
        .TXD          (txd)
`ifdef IO_UART_RX_EN
        ,
        .RXD          (rxd)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] io_addr(input logic [2:0] off);
        return 32'h0040_0000 | {27'd0, off, 2'b00};
    endfunction

    task automatic read_reg(input logic [2:0] off, output logic [31:0] d);
        addr = io_addr(off);
        #1;
        d = rdata;
    endtask

    // Assumes the caller is just after a falling edge.
    task automatic drive_write(input logic [2:0] off, input logic [31:0] d);
        addr  = io_addr(off);
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
        last_wr_cyc = cyc;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        #1;
        drive_write(off, d);
    endtask

    // Accept/drop decided from the pre-edge occupancy: pushes accepted minus frames started.
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        #1;
        if ((accepted - started) < DEPTH) begin
            exp_q.push_back(b);
            accepted++;
        end else begin
            model_ovf = 1'b1;
        end
        drive_write(OFF_DAT, {24'd0, b});
    endtask

    function automatic logic [31:0] model_status(input bit frame_active);
        int pend;
        pend = accepted - started;
        return (pend << 4) | (32'(model_ovf) << 2) | (32'(pend == DEPTH) << 1) |
               32'(frame_active || pend > 0);
    endfunction

    task automatic do_reset();
        logic [31:0] d;
        @(negedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        accepted  = 0;
        started   = 0;
        model_ovf = 1'b0;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_leds", {27'd0, leds}, 32'd0);
        read_reg(OFF_STATUS, d);
        check("rst_status", d, 32'd0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        addr = io_addr(OFF_STATUS);
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(rdata[0] == 1'b0 && exp_q.size() == 0) && n < max_cyc);
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles (queue %0d), required idle", name, n, exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [7:0] eb;
        logic [9:0] fb, act_fb;
        bit ok, aborted;
        int s;
        forever begin
            @(negedge clk);
            if (resetn && txd === 1'b0) begin
                s = cyc;
                started++;
                start_q.push_back(s);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: start bit at cycle %0d, required no frame", s);
                    eb = 8'h00;
                end else begin
                    eb = exp_q[0];
                end
                fb      = {1'b1, eb, 1'b0};
                act_fb  = '0;
                ok      = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!resetn) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % DIV == DIV / 2) act_fb[k / DIV] = txd;
                    if (txd !== fb[k / DIV]) ok = 1'b0;
                end
                if (!aborted && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL frame_bits @%0d: got %b expected %b (byte 0x%0h)", s, act_fb, fb, eb);
                    end
                end
            end
        end
    end

`ifdef IO_UART_RX_EN
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fb;
        fb = {stop_bit, b, 1'b0};
        @(negedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rxd = fb[i];
            repeat (DIV) @(posedge clk);
        end
        rxd = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] d;
        logic [4:0]  v;
        logic [7:0]  b;
        int n, s0, c0;

        repeat (2) @(posedge clk);
        do_reset();
        for (int off = 3; off < 8; off++) begin
            read_reg(3'(off), d);
            check($sformatf("rst_read_off%0d", off), d, 32'd0);
        end

        // LED register, including a write to an unmapped offset.
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 5'h1F : 5'($urandom_range(0, 31));
            bus_write(OFF_LEDS, {$urandom_range(0, 32'h07FF_FFFF), v});
            check("leds_out", {27'd0, leds}, {27'd0, v});
            read_reg(OFF_LEDS, d);
            check("leds_read", d, {27'd0, v});
        end
        bus_write(3'd5, $urandom);
        check("unmapped_wr_leds", {27'd0, leds}, {27'd0, v});
        read_reg(3'd5, d);
        check("unmapped_read", d, 32'd0);
        read_reg(OFF_DAT, d);
        check("uart_dat_read", d, 32'd0);
        do_reset();

        // Single frame: latency and busy duration.
        start_q.delete();
        push_byte(8'hA5);
        c0 = last_wr_cyc;
        addr = io_addr(OFF_STATUS);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdata[0] !== 1'b0 && n < 300);
        check("busy_fall_cycle", cyc, c0 + 1 + FRAME);
        check("start_latency", start_q.size() > 0 ? start_q[0] : -1, c0 + 1);
        wait_idle(50, "single_idle");

        // Overflow: one frame running, then DEPTH+1 back-to-back pushes.
        start_q.delete();
        push_byte(8'($urandom_range(0, 255)));
        repeat (3) @(posedge clk);
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom_range(0, 255)));
        read_reg(OFF_STATUS, d);
        check("burst_status", d, model_status(1'b1));
        wait_idle(FRAME * (DEPTH + 3), "burst_idle");
        check("burst_frames", start_q.size(), DEPTH + 1);
        for (int i = 1; i < start_q.size(); i++)
            check($sformatf("frame_gap%0d", i), start_q[i] - start_q[i-1], FRAME);
        read_reg(OFF_STATUS, d);
        check("ovf_sticky", d, model_status(1'b0));
        bus_write(OFF_STATUS, 32'h4);
        model_ovf = 1'b0;
        read_reg(OFF_STATUS, d);
        check("ovf_cleared", d, model_status(1'b0));

        // Reset in the middle of a frame, then a clean frame.
        bus_write(OFF_LEDS, 32'($urandom_range(1, 31)));
        s0 = started;
        push_byte(8'($urandom_range(0, 255)));
        n = 0;
        while (started == s0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("midframe_started", started, s0 + 1);
        repeat (34) @(negedge clk);
        do_reset();
        push_byte(8'($urandom_range(0, 255)));
        wait_idle(FRAME + 50, "post_reset_idle");

`ifdef IO_UART_RX_EN
        send_rx(8'h3C, 1'b1);
        read_reg(OFF_RX, d);
        check("rx_first", d, 32'h13C);
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b1);
        read_reg(OFF_RX, d);
        check("rx_second", d, 32'h100 | {24'd0, b});
        read_reg(OFF_STATUS, d);
        check("rx_ovr_set", {31'd0, d[3]}, 32'd1);
        bus_write(OFF_RX, 32'd0);
        read_reg(OFF_RX, d);
        check("rx_valid_clr", d, {24'd0, b});
        bus_write(OFF_STATUS, 32'h8);
        read_reg(OFF_STATUS, d);
        check("rx_ovr_clr", {31'd0, d[3]}, 32'd0);
        send_rx(8'($urandom_range(0, 255)), 1'b0);
        read_reg(OFF_RX, d);
        check("rx_bad_stop", d, {24'd0, b});
        for (int off = 5; off < 8; off++) begin
            read_reg(3'(off), d);
            check($sformatf("rx_unmapped%0d", off), d, 32'd0);
        end
`endif

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
